// File: rtl/traffic_sensor_cond_pkg.sv
// Shared types and constants for the traffic-light front end and FSM.
// Latency: none (declarations only).
// Backpressure: none.
package traffic_pkg;

   // Debounce channel states; clean level is 1 in STABLE_HI and CHK_LO.
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } deb_state_t;

   // Light encodings consumed by the downstream traffic-light FSM.
   localparam logic [2:0] RED_STOP    = 3'b111;
   localparam logic [2:0] GREEN_GO    = 3'b011;
   localparam logic [2:0] YELLOW_WAIT = 3'b001;

endpackage

// File: rtl/traffic_sensor_cond_if.sv
// Sensor-side bundle: raw street sensors in, conditioned levels and strobes out.
// Latency: none (wiring only).
// Backpressure: none; every output is a level or a single-cycle pulse.
interface traffic_sensor_cond_if;
   logic sa_raw;
   logic sb_raw;
   logic sa;
   logic sb;
   logic step;
   logic sa_edge;
   logic sb_edge;

   // master: the side that drives the raw sensors and consumes the results
   modport master (output sa_raw, sb_raw,
                   input  sa, sb, step, sa_edge, sb_edge);

   // slave: the conditioner itself
   modport slave  (input  sa_raw, sb_raw,
                   output sa, sb, step, sa_edge, sb_edge);
endinterface

// File: rtl/traffic_sensor_cond_debounce.sv
// One sensor channel: SYNC_STAGES-flop synchroniser, 4-state debounce FSM, rising-edge pulse.
// Latency: a stable input change appears on clean after SYNC_STAGES+DEB_CYCLES edges.
// Backpressure: none; free-running, outputs are registered.
module sensor_debounce
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES  = 1_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic clean_d_o,
   output logic edge_o
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   deb_state_t             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   edge_q, edge_d;
   logic                   cnt_done;

   // Plain shift chain: no logic between stages so metastability can settle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // With a single required cycle the check state must accept immediately.
   assign cnt_done = (cnt_q == CNT_LAST) || (DEB_CYCLES == 1);

   // Debounce state, counter, clean level and edge pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         edge_q  <= edge_d;
      end
   end

   // Next-state: a change must hold for DEB_CYCLES consecutive samples; any
   // reversion during the check returns to the current stable state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      edge_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (synced) begin
               state_d = CHK_HI;
               cnt_d   = CW'(1);
            end
         end
         CHK_HI: begin
            if (!synced) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               clean_d = 1'b1;
               edge_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         STABLE_HI: begin
            if (!synced) begin
               state_d = CHK_LO;
               cnt_d   = CW'(1);
            end
         end
         CHK_LO: begin
            if (synced) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               clean_d = 1'b0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            clean_d = 1'b0;
         end
      endcase
   end

   // Next clean value is exported so the parent can register it alongside its own state.
   assign clean_d_o = clean_d;
   assign edge_o    = edge_q;

endmodule

// File: rtl/traffic_sensor_cond.sv
// Sensor conditioner ahead of the traffic FSM: two debounced channels plus a step strobe; optional request latch via TRAFFIC_SENSOR_LATCH_EN.
// Latency: sa/sb follow raw after SYNC_STAGES+DEB_CYCLES edges; step every TICK_DIV cycles, first one TICK_DIV cycles after reset.
// Backpressure: none; all outputs registered and free-running.
module traffic_sensor_cond
   import traffic_pkg::*;
#(
   parameter int TICK_DIV    = 100_000_000,
   parameter int DEB_CYCLES  = 1_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   traffic_sensor_cond_if.slave bus
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic          sa_clean_d, sb_clean_d;
   logic          sa_edge, sb_edge;
   logic [TW-1:0] tick_q, tick_d;
   logic          step_q, step_d;
   logic          sa_q, sa_d;
   logic          sb_q, sb_d;

   sensor_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_deb_a (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (bus.sa_raw),
      .clean_d_o (sa_clean_d),
      .edge_o    (sa_edge)
   );

   sensor_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_deb_b (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (bus.sb_raw),
      .clean_d_o (sb_clean_d),
      .edge_o    (sb_edge)
   );

   // Free-running tick: wrap at TICK_DIV-1, step registered one cycle later.
   always_comb begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
      step_d = (tick_q == TICK_LAST);
   end

   // Sensor outputs: latch holds a request until the cycle after a step
   // unless the car is still present; otherwise just the clean level.
   always_comb begin
`ifdef TRAFFIC_SENSOR_LATCH_EN
      sa_d = sa_clean_d | (sa_q & ~step_q);
      sb_d = sb_clean_d | (sb_q & ~step_q);
`else
      sa_d = sa_clean_d;
      sb_d = sb_clean_d;
`endif
   end

   // Tick phase and output registers; reset discards phase and requests.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q <= '0;
         step_q <= 1'b0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
      end else begin
         tick_q <= tick_d;
         step_q <= step_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
      end
   end

   assign bus.sa      = sa_q;
   assign bus.sb      = sb_q;
   assign bus.step    = step_q;
   assign bus.sa_edge = sa_edge;
   assign bus.sb_edge = sb_edge;

endmodule

// File: doc/traffic_sensor_cond.md
Name: traffic_sensor_cond

Overview:
Front-end conditioner placed directly upstream of the traffic-light FSM.
- Synchronises the raw street sensors sa_raw and sb_raw and debounces them into clean levels.
- Generates a one-cycle step strobe. The FSM uses this strobe as its state-advance enable, so it never needs a gated or divided clock.
- All outputs are registered and valid in the clk domain.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per step pulse (1 s at 100 MHz); legal range >= 2.
- DEB_CYCLES, 1_000_000: consecutive stable cycles required before a clean level changes (10 ms); legal range >= 1.
- SYNC_STAGES, 2: flop stages in each input synchroniser; legal range >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- sa_raw  in  1  street A sensor, asynchronous, may bounce.
- sb_raw  in  1  street B sensor, asynchronous, may bounce.
- sa  out  1  debounced street A level, to the FSM.
- sb  out  1  debounced street B level, to the FSM.
- step  out  1  one-cycle pulse every TICK_DIV cycles, FSM advance enable.
- sa_edge  out  1  one-cycle pulse on a debounced 0->1 transition of sa.
- sb_edge  out  1  one-cycle pulse on a debounced 0->1 transition of sb.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchroniser flops, debounce counters and the tick counter go to 0.
  - Outputs sa, sb, step, sa_edge and sb_edge go to 0.
  - Each debounce FSM goes to STABLE_LO.
- Synchroniser: SYNC_STAGES flops per channel; no logic between stages.
- Debounce FSM, one per channel, 4 states:
  - STABLE_LO, clean=0: synced=1 -> CHK_HI with cnt=1; otherwise stay.
  - CHK_HI, clean=0:
    - synced=0 -> STABLE_LO with cnt=0 (glitch rejected).
    - synced=1 and cnt==DEB_CYCLES-1 -> STABLE_HI, clean=1, edge pulse.
    - otherwise cnt+1.
  - STABLE_HI, clean=1: synced=0 -> CHK_LO with cnt=1.
  - CHK_LO, clean=1:
    - synced=1 -> STABLE_HI (glitch rejected).
    - synced=0 and cnt==DEB_CYCLES-1 -> STABLE_LO, clean=0.
    - otherwise cnt+1.
  - DEB_CYCLES=1: CHK states transition on their first cycle.
- Debounce latency: a clean input change reaches sa/sb exactly SYNC_STAGES+DEB_CYCLES clk edges after it is sampled.
- Edge pulses: sa_edge/sb_edge rise in the same cycle clean goes 0->1 and last one cycle. Falling transitions produce no pulse.
- Tick counter:
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1 and wraps to 0. No overflow is possible.
  - step=1 exactly in the cycle after the count reaches TICK_DIV-1, i.e. registered.
  - The first step comes TICK_DIV cycles after reset deasserts. Pulses are then exactly TICK_DIV cycles apart.
  - step is free-running and independent of the sensors.
- Simultaneous events:
  - Channels are fully independent; sa_edge, sb_edge and step may all be high in the same cycle.
  - Ordering and priority are left to the FSM.
- Reset mid-operation: all in-progress debounce counts and the tick phase are discarded; no pulse is emitted on reset release.

Optional Feature:
- Macro TRAFFIC_SENSOR_LATCH_EN, when defined:
  - sa/sb become request latches. They are set by the debounced 0->1 transition, or hold while the clean level is 1.
  - They clear only in the cycle after a step pulse, and only if the clean level is 0 at that point.
  - Effect: a car present for a short time between steps is never missed by the FSM.
- Without the macro: sa/sb equal the clean debounced levels directly.
- sa_edge/sb_edge behaviour is identical in both builds.

Decomposition:
- Package traffic_pkg holds:
  - deb_state_t enum {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO}, 2 bits.
  - The light encoding constants RED_STOP=3'b111, GREEN_GO=3'b011, YELLOW_WAIT=3'b001, shared with the FSM.
- Sub-module sensor_debounce: one channel containing synchroniser, debounce FSM, counter and edge output, parameterised by DEB_CYCLES and SYNC_STAGES.
  - traffic_sensor_cond instantiates it twice and adds the tick counter and the optional latch.

Test Plan:
All scenarios use TICK_DIV=10, DEB_CYCLES=4, SYNC_STAGES=2.
1. reset=0 for 3 cycles, then reset=1 with sensors at 0 -> all outputs 0; step first high on cycle 10 after release and every 10th cycle after that.
2. sa_raw 0->1 held -> sa=1 and sa_edge=1 (single cycle) at edge 6 after the change; sb, sb_edge stay 0.
3. sa_raw toggles 1,1,1,0 repeatedly (3-cycle high bursts) -> sa never rises, sa_edge never pulses.
4. sb_raw high for 20 cycles, then 0 -> sb rises at edge 6 and falls 6 edges after the drop, with one sb_edge; step cadence is undisturbed.
5. reset asserted while sa is in CHK_HI at cnt=2 -> sa stays 0 and, after release, needs the full 6 cycles of stable input.
6. TRAFFIC_SENSOR_LATCH_EN: sa_raw high for 8 cycles between steps -> sa held 1 until the cycle after the next step, then 0. Without the macro, sa falls 6 cycles after sa_raw drops.
